// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock, start/busy/done handshake.
// Optional BIN2BCD_BLANK_EN adds a registered leading-zero blanking mask (blank_out).
module bin_to_bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
`ifdef BIN2BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank_out
`endif
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [BW-1:0]     scratch_q, scratch_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [BW-1:0]     bcd_q, bcd_d;

  logic [BW-1:0]         adj;
  logic [BW+BIN_W-1:0]   cat_shift;
  logic [BW-1:0]         scratch_sh;
  logic [BIN_W-1:0]      bin_sh;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = (scratch_q[gi*4 +: 4] >= 4'd5) ?
                              scratch_q[gi*4 +: 4] + 4'd3 : scratch_q[gi*4 +: 4];
    end
  endgenerate

  // The adjusted top-nibble MSB falls off the end; it is always 0 given DIGITS is large enough.
  assign cat_shift  = {adj, bin_q} << 1;
  assign scratch_sh = cat_shift[BW+BIN_W-1:BIN_W];
  assign bin_sh     = cat_shift[BIN_W-1:0];

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d, blank_w;

  assign blank_w[0] = 1'b0;
  generate
    for (gi = 1; gi < DIGITS; gi++) begin : g_blank
      assign blank_w[gi] = (scratch_sh[BW-1:4*gi] == '0);
    end
  endgenerate

  assign blank_out = blank_q;
`endif

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
`ifdef BIN2BCD_BLANK_EN
    blank_d   = blank_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d     = bin_in;
          scratch_d = '0;
          cnt_d     = CW'(BIN_W);
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = scratch_sh;
        bin_d     = bin_sh;
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = scratch_sh;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
`ifdef BIN2BCD_BLANK_EN
          blank_d = blank_w;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
`ifdef BIN2BCD_BLANK_EN
      blank_q   <= {{(DIGITS-1){1'b1}}, 1'b0};
`endif
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
`ifdef BIN2BCD_BLANK_EN
      blank_q   <= blank_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: directed handshake/timing cases plus a random sweep against a decimal model.
module tb_bin_to_bcd_seq;
  localparam int BIN_W  = 16;
  localparam int DIGITS = 5;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [BIN_W-1:0]  bin_in = '0;
  logic              busy;
  logic              done;
  logic [4*DIGITS-1:0] bcd_out;
`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_out;
`endif

  int total = 0;
  int passed = 0;
  int failed = 0;

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
`ifdef BIN2BCD_BLANK_EN
    ,
    .blank_out (blank_out)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decimal digits of v packed one per nibble, using plain division.
  function automatic logic [4*DIGITS-1:0] model_bcd(input longint v);
    logic [4*DIGITS-1:0] r = '0;
    longint p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] model_blank(input longint v);
    logic [DIGITS-1:0] r = '0;
    longint p = 10;
    for (int i = 1; i < DIGITS; i++) begin
      r[i] = (v < p);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic nibbles_ok(input logic [4*DIGITS-1:0] b);
    logic ok = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (b[i*4 +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  function automatic longint bcd_value(input logic [4*DIGITS-1:0] b);
    longint s = 0;
    longint p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      s = s + longint'(b[i*4 +: 4]) * p;
      p = p * 10;
    end
    return s;
  endfunction

  // Steps from just after an edge until done is seen; optionally pulses a stray start mid-conversion.
  task automatic wait_done(input int inject_at, output int cycles, output int busy_cnt, output bit timeout);
    cycles = 0;
    busy_cnt = 0;
    timeout = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (busy) busy_cnt++;
      if (cycles == inject_at) begin start = 1'b1; bin_in = 16'd9; end
      if (cycles == inject_at + 1) start = 1'b0;
      @(posedge clock); #1;
      cycles++;
      if (done) begin timeout = 1'b0; break; end
    end
    start = 1'b0;
  endtask

  // Full conversion: issue start, check timing, result and the one-cycle done pulse.
  task automatic convert(input string tag, input logic [BIN_W-1:0] v, input int inject_at, input bit detail);
    int cyc, bcnt;
    bit to;
    logic [4*DIGITS-1:0] held;
    bin_in = v;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    bin_in = $urandom_range(0, 65535);
    wait_done(inject_at, cyc, bcnt, to);
    check({tag, "_timeout"}, 64'(to), 64'd0);
    if (detail) begin
      check({tag, "_latency"}, 64'(cyc), 64'(BIN_W));
      check({tag, "_busy_cycles"}, 64'(bcnt), 64'(BIN_W));
      check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    end
    check({tag, "_bcd"}, 64'(bcd_out), 64'(model_bcd(longint'(v))));
    check({tag, "_nibbles"}, 64'(nibbles_ok(bcd_out)), 64'd1);
    check({tag, "_sum"}, 64'(bcd_value(bcd_out)), 64'(v));
`ifdef BIN2BCD_BLANK_EN
    check({tag, "_blank"}, 64'(blank_out), 64'(model_blank(longint'(v))));
`endif
    held = bcd_out;
    @(posedge clock); #1;
    check({tag, "_done_single"}, 64'(done), 64'd0);
    check({tag, "_hold"}, 64'(bcd_out), 64'(held));
    if (detail) $display("conv %s bin=%0d bcd=%05h cycles=%0d", tag, v, bcd_out, cyc);
  endtask

  initial begin
    int cyc, bcnt, seen;
    bit to;
    logic [BIN_W-1:0] rv;

    #12;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_bcd", 64'(bcd_out), 64'd0);
`ifdef BIN2BCD_BLANK_EN
    check("reset_blank", 64'(blank_out), 64'(5'b11110));
`endif
    reset = 1'b0;
    @(posedge clock); #1;

    convert("zero", 16'd0, -1, 1'b1);
    convert("max", 16'd65535, -1, 1'b1);
    convert("v42", 16'd42, -1, 1'b1);

    // Stray start during busy must be ignored; then restart in the done cycle.
    bin_in = 16'd1234;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(3, cyc, bcnt, to);
    check("ign_timeout", 64'(to), 64'd0);
    check("ign_latency", 64'(cyc), 64'(BIN_W));
    check("ign_bcd", 64'(bcd_out), 64'h01234);
    $display("conv ignore bin=1234 bcd=%05h cycles=%0d", bcd_out, cyc);
    bin_in = 16'd9;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1);
    check("b2b_done_low", 64'(done), 64'd0);
    wait_done(-1, cyc, bcnt, to);
    check("b2b_timeout", 64'(to), 64'd0);
    check("b2b_gap", 64'(cyc + 1), 64'(BIN_W + 1));
    check("b2b_bcd", 64'(bcd_out), 64'h00009);
    $display("conv b2b bin=9 bcd=%05h gap=%0d", bcd_out, cyc + 1);
    @(posedge clock); #1;

    // Asynchronous reset mid-conversion, applied off the clock edge.
    bin_in = 16'd4321;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (7) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_bcd", 64'(bcd_out), 64'd0);
    #3;
    reset = 1'b0;
    seen = 0;
    repeat (30) begin
      @(posedge clock); #1;
      if (done || busy) seen++;
    end
    check("rst_no_done", 64'(seen), 64'd0);
    $display("conv reset_mid bin=4321 aborted");

    for (int n = 0; n < 1000; n++) begin
      rv = BIN_W'($urandom);
      convert("rand", rv, -1, (n < 20));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
